// File: rtl/sign_ext_neg.sv
// sign_ext_neg
//
// Registered immediate-processing stage between instruction decode and the
// ALU operand muxes. A raw two's-complement immediate is sign-extended to
// the datapath width by two independent circuits (bit replication and an
// arithmetic right shift). The replicated value is negated, and the value
// plus its negation is summed as a self-check. Any disagreement between the
// two extensions, or a nonzero sum, raises mismatch. Latency is one cycle.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset, clears every output
//   valid_in       qualifies imm this cycle
//   imm            raw immediate, IMM_W bits, two's complement
//   valid_out      outputs carry a result produced at the last edge
//   ext_imm        sign extension by replication
//   ext_imm2       sign extension by arithmetic shift
//   minus_ext_imm  two's-complement negation of ext_imm
//   zero_sum       ext_imm + minus_ext_imm, modulo 2^XLEN
//   mismatch       self-check failure for the registered result
module sign_ext_neg #(
  parameter int IMM_W = 12,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [IMM_W-1:0] imm,
  output logic             valid_out,
  output logic [XLEN-1:0]  ext_imm,
  output logic [XLEN-1:0]  ext_imm2,
  output logic [XLEN-1:0]  minus_ext_imm,
  output logic [XLEN-1:0]  zero_sum,
  output logic             mismatch
);

  localparam int PAD_W = XLEN - IMM_W;

  // Replication: copy the sign bit into every upper position.
  function automatic logic [XLEN-1:0] ext_replicate(input logic [IMM_W-1:0] v);
    ext_replicate = {{PAD_W{v[IMM_W-1]}}, v};
  endfunction

  // Shift: park the immediate at the top of the word, then let the
  // arithmetic right shift drag the sign bit back down. Deliberately shares
  // nothing with ext_replicate so the two can cross-check each other.
  function automatic logic [XLEN-1:0] ext_shift(input logic [IMM_W-1:0] v);
    logic signed [XLEN-1:0] placed;
    placed    = $signed({v, {PAD_W{1'b0}}});
    ext_shift = placed >>> PAD_W;
  endfunction

  // Two's-complement negation; wraps modulo 2^XLEN. A sign-extended IMM_W
  // value can never be the most negative XLEN value, so no overflow case.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    negate = ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: combinational results from the sampled immediate.
  logic [XLEN-1:0] ext_p0;
  logic [XLEN-1:0] ext2_p0;
  logic [XLEN-1:0] neg_p0;
  logic [XLEN-1:0] sum_p0;
  logic            mis_p0;

  assign ext_p0  = ext_replicate(imm);
  assign ext2_p0 = ext_shift(imm);
  assign neg_p0  = negate(ext_p0);
  assign sum_p0  = ext_p0 + neg_p0;
  assign mis_p0  = (ext_p0 != ext2_p0) || (sum_p0 != '0);

  // Stage p1: output registers. Data loads only on valid_in and otherwise
  // holds; reset clears data as well so outputs read 0 after reset.
  logic            vld_p1;
  logic [XLEN-1:0] ext_p1;
  logic [XLEN-1:0] ext2_p1;
  logic [XLEN-1:0] neg_p1;
  logic [XLEN-1:0] sum_p1;
  logic            mis_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ext_p1  <= '0;
      ext2_p1 <= '0;
      neg_p1  <= '0;
      sum_p1  <= '0;
      mis_p1  <= 1'b0;
    end else begin
      vld_p1 <= valid_in;
      if (valid_in) begin
        ext_p1  <= ext_p0;
        ext2_p1 <= ext2_p0;
        neg_p1  <= neg_p0;
        sum_p1  <= sum_p0;
        mis_p1  <= mis_p0;
      end
    end
  end

  assign valid_out     = vld_p1;
  assign ext_imm       = ext_p1;
  assign ext_imm2      = ext2_p1;
  assign minus_ext_imm = neg_p1;
  assign zero_sum      = sum_p1;
  assign mismatch      = mis_p1;

endmodule

// File: tb/tb_sign_ext_neg.sv
// Self-checking bench for sign_ext_neg: directed steps with a scoreboard
// queue of expected results, checked one cycle after each valid input.
module tb_sign_ext_neg;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [11:0] imm;
  logic        valid_out;
  logic [31:0] ext_imm;
  logic [31:0] ext_imm2;
  logic [31:0] minus_ext_imm;
  logic [31:0] zero_sum;
  logic        mismatch;

  sign_ext_neg #(.IMM_W(12), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .imm           (imm),
    .valid_out     (valid_out),
    .ext_imm       (ext_imm),
    .ext_imm2      (ext_imm2),
    .minus_ext_imm (minus_ext_imm),
    .zero_sum      (zero_sum),
    .mismatch      (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ext;
    logic [31:0] neg;
  } exp_t;

  exp_t queue_exp[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a signed cast for extension, subtraction from zero for
  // negation.
  function automatic exp_t model(input logic [11:0] v);
    logic signed [11:0] s;
    logic signed [31:0] e;
    exp_t r;
    s     = v;
    e     = s;
    r.ext = e;
    r.neg = 32'd0 - r.ext;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_ext"},   ext_imm,            32'd0);
    chk({tag, "_ext2"},  ext_imm2,           32'd0);
    chk({tag, "_neg"},   minus_ext_imm,      32'd0);
    chk({tag, "_sum"},   zero_sum,           32'd0);
    chk({tag, "_mis"},   {31'd0, mismatch},  32'd0);
  endtask

  // One clock: drive at negedge, push expectation, compare 1 after posedge.
  task automatic cycle(input logic v, input logic [11:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    valid_in = v;
    imm      = d;
    if (v) queue_exp.push_back(model(d));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    if (valid_out === 1'b1) begin
      if (queue_exp.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = queue_exp.pop_front();
        last_exp = e;
      end
    end
    chk({tag, "_ext"},  ext_imm,           last_exp.ext);
    chk({tag, "_ext2"}, ext_imm2,          last_exp.ext);
    chk({tag, "_neg"},  minus_ext_imm,     last_exp.neg);
    chk({tag, "_sum"},  zero_sum,          32'd0);
    chk({tag, "_mis"},  {31'd0, mismatch}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    imm      = 12'd0;
    last_exp = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and directed sequence with literal expected constants.
    cycle(1'b1, 12'd5, "imm5");
    chk("imm5_const_ext", ext_imm,       32'h00000005);
    chk("imm5_const_neg", minus_ext_imm, 32'hFFFFFFFB);

    cycle(1'b1, 12'd5,            "seq5");
    chk("seq5_c", minus_ext_imm, 32'hFFFFFFFB);
    cycle(1'b1, 12'd12,           "seq12");
    chk("seq12_c", ext_imm, 32'h0000000C);
    cycle(1'b1, 12'hFFB,          "seqm5");
    chk("seqm5_c", ext_imm, 32'hFFFFFFFB);
    cycle(1'b1, 12'hFF4,          "seqm12");
    chk("seqm12_c", minus_ext_imm, 32'h0000000C);
    cycle(1'b1, 12'd1337,         "seq1337");
    chk("seq1337_c", minus_ext_imm, 32'hFFFFFAC7);
    cycle(1'b1, 12'h81D,          "seqm2019");
    chk("seqm2019_c", ext_imm, 32'hFFFFF81D);
    chk("seqm2019_n", minus_ext_imm, 32'h000007E3);

    // Boundaries.
    cycle(1'b1, 12'h800, "min");
    chk("min_c_ext", ext_imm,       32'hFFFFF800);
    chk("min_c_neg", minus_ext_imm, 32'h00000800);
    cycle(1'b1, 12'h7FF, "max");
    chk("max_c_ext", ext_imm,       32'h000007FF);
    chk("max_c_neg", minus_ext_imm, 32'hFFFFF801);
    cycle(1'b1, 12'h000, "zero");
    chk("zero_c_neg", minus_ext_imm, 32'd0);

    // Hold: valid result, then idle cycles with imm changing.
    cycle(1'b1, 12'h9A5, "hold_load");
    cycle(1'b0, 12'h123, "hold1");
    cycle(1'b0, 12'h456, "hold2");
    chk("hold_c_ext", ext_imm, 32'hFFFFF9A5);

    // Async reset mid-stream: the pending input must be dropped.
    cycle(1'b1, 12'h321, "pre_rst");
    @(negedge clk);
    valid_in = 1'b1;
    imm      = 12'h777;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b1;
    last_exp = '0;
    @(posedge clk);
    #1;
    check_all_zero("rst_release_idle");
    cycle(1'b1, 12'hABC, "post_rst");
    chk("post_rst_c", ext_imm, 32'hFFFFFABC);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 4096; i++) begin
      cycle(1'b1, 12'(i), "sweep");
    end
    cycle(1'b0, 12'd0, "sweep_tail");
    chk("queue_drained", 32'(queue_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_ext_neg.md
# sign_ext_neg

Registered immediate-processing block for the integer datapath. It sign-extends a 12-bit instruction immediate to 32 bits using two independent implementations, then produces the two's-complement negation of the result. It also forms a self-check sum (extended value plus its negation) and flags any disagreement. It sits between instruction decode and the ALU operand muxes.

## Interface
- IMM_W, 12, immediate width in bits; bit IMM_W-1 is the sign bit.
- XLEN, 32, datapath width; must be greater than IMM_W.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  qualifies imm for this cycle.
- imm  input  IMM_W  raw immediate, two's complement.
- valid_out  output  1  outputs below carry a new result.
- ext_imm  output  XLEN  sign-extended imm, produced by the replication implementation.
- ext_imm2  output  XLEN  sign-extended imm, produced by the shift implementation.
- minus_ext_imm  output  XLEN  two's-complement negation of ext_imm.
- zero_sum  output  XLEN  ext_imm + minus_ext_imm, modulo 2^XLEN.
- mismatch  output  1  self-check failure for the current result.

## Operation
- Replication extension (ext_imm): upper XLEN-IMM_W bits are copies of imm[IMM_W-1]; lower bits equal imm.
- Shift extension (ext_imm2):
  - Place imm in the top IMM_W bits of an XLEN word.
  - Arithmetic-shift right by XLEN-IMM_W.
  - Must be a separate datapath from the replication implementation, not a copy of it.
- Negation: minus_ext_imm = (~ext_imm) + 1, truncated to XLEN bits.
  - neg(0) = 0.
  - No overflow case exists for a sign-extended 12-bit value: -2048 negates to +2048.
- zero_sum = ext_imm + minus_ext_imm, carry out discarded; equals 0 for every legal input.
- mismatch = (ext_imm != ext_imm2) OR (zero_sum != 0), computed from the values being registered.
- All arithmetic is unsigned bit-vector arithmetic at XLEN width; no saturation.

## Timing
- Latency is 1 cycle: imm sampled at edge N with valid_in=1 appears on the outputs after edge N, and valid_out=1 for that cycle.
- valid_in=0 at an edge:
  - valid_out goes 0 at that edge.
  - All data outputs and mismatch hold their last values.
- Back-to-back valid inputs are accepted every cycle; there is no backpressure.
- Reset (rst_n=0) immediately forces all outputs to 0 regardless of clk: valid_out, ext_imm, ext_imm2, minus_ext_imm, zero_sum, mismatch.
  - Reset asserted mid-stream drops the in-flight result.
  - The first valid output after rst_n rises is the first input sampled with rst_n high.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then imm=5 with valid -> next cycle:
  - ext_imm = ext_imm2 = 0x00000005.
  - minus_ext_imm = 0xFFFFFFFB.
  - zero_sum = 0, mismatch = 0, valid_out = 1.
- Sequence 5, 12, -5, -12, 1337, -2019 on consecutive cycles -> each one cycle later:
  - ext_imm: 0x00000005, 0x0000000C, 0xFFFFFFFB, 0xFFFFFFF4, 0x00000539, 0xFFFFF81D.
  - minus_ext_imm: 0xFFFFFFFB, 0xFFFFFFF4, 0x00000005, 0x0000000C, 0xFFFFFAC7, 0x000007E3.
  - ext_imm2 matches ext_imm and zero_sum = 0 for every entry.
- Boundaries:
  - imm=0x800 -> ext 0xFFFFF800, minus 0x00000800.
  - imm=0x7FF -> ext 0x000007FF, minus 0xFFFFF801.
  - imm=0x000 -> all data outputs 0.
- Hold: valid result on the outputs, then valid_in=0 with imm changing -> valid_out=0 and data outputs unchanged.
- Async reset: assert rst_n=0 between clock edges while outputs are nonzero -> all outputs 0 before the next edge; after release, the first valid input appears with 1-cycle latency.
- Exhaustive sweep of all 4096 imm values -> mismatch never 1, and ext_imm matches a reference signed cast.
